// File: rtl/sampler_pkg.sv
// sampler_pkg: shared FSM states, key indices and voice lookup helpers
package sampler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    TAIL = 2'd2
  } state_e;

  localparam logic [3:0] KEY_Q = 4'd15;
  localparam logic [3:0] KEY_W = 4'd14;
  localparam logic [3:0] KEY_E = 4'd13;
  localparam logic [3:0] KEY_R = 4'd12;
  localparam logic [3:0] KEY_T = 4'd11;
  localparam logic [3:0] KEY_Y = 4'd10;
  localparam logic [3:0] KEY_U = 4'd9;
  localparam logic [3:0] KEY_I = 4'd8;
  localparam logic [3:0] KEY_O = 4'd7;
  localparam logic [3:0] KEY_P = 4'd6;
  localparam logic [3:0] KEY_A = 4'd5;
  localparam logic [3:0] KEY_S = 4'd4;
  localparam logic [3:0] KEY_D = 4'd3;
  localparam logic [3:0] KEY_F = 4'd2;
  localparam logic [3:0] KEY_G = 4'd1;
  localparam logic [3:0] KEY_H = 4'd0;

  // Voice code for a key; only the top four keys have dedicated codes.
  function automatic logic [2:0] sound_code(input logic [3:0] idx);
    sound_code = (idx == KEY_Q) ? 3'b001 :
                 (idx == KEY_W) ? 3'b010 :
                 (idx == KEY_E) ? 3'b100 :
                 (idx == KEY_R) ? 3'b110 : 3'b011;
  endfunction

  // Highest set bit of a key vector; KEY_H when the vector is empty.
  function automatic logic [3:0] highest_key(input logic [15:0] v);
    highest_key = KEY_H;
    for (int i = 0; i < 16; i++)
      if (v[i]) highest_key = 4'(i);
  endfunction

endpackage

// File: rtl/key_edge_sync.sv
// key_edge_sync: two-flop key synchronizer with rising-edge press detection
module key_edge_sync (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] keys_in,
  output logic [15:0] sync_out,
  output logic [15:0] press_out
);

  logic [15:0] s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
  logic [1:0]  settle_q, settle_d;
  logic        ready;

  // Press detection stays off until the pipeline has refilled after reset,
  // so keys held through reset never look like fresh presses.
  assign ready = settle_q == 2'd3;

  // Shift pipeline and saturating settle counter.
  always_comb begin
    s1_d     = keys_in;
    s2_d     = s1_q;
    prev_d   = s2_q;
    settle_d = ready ? settle_q : settle_q + 2'd1;
  end

  // Synchronizer and history flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      prev_q   <= '0;
      settle_q <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      prev_q   <= prev_d;
      settle_q <= settle_d;
    end
  end

  assign sync_out  = s2_q;
  assign press_out = ready ? (s2_q & ~prev_q) : '0;

endmodule

// File: rtl/key_voice_scheduler.sv
// key_voice_scheduler: monophonic key-to-voice scheduler with minimum gate time and square-wave tone
module key_voice_scheduler
  import sampler_pkg::*;
#(
  parameter int MIN_HOLD  = 50000,
  parameter int BASE_HALF = 95556,
  parameter int STEP      = 4000
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        enable,
  input  logic [15:0] keys,
  output logic [2:0]  sound,
  output logic        voice_valid,
  output logic [3:0]  voice_idx,
  output logic        audio_out
);

  localparam logic [23:0] HOLD_MAX = 24'(MIN_HOLD - 1);

  state_e      state_q, state_d;
  logic [15:0] sync, press_raw, press;
  logic [3:0]  idx_q, idx_d, tgt;
  logic [23:0] hold_q, hold_d;
  logic [31:0] tone_q, tone_d, half;
  logic [2:0]  sound_q, sound_d;
  logic        audio_q, audio_d, valid_q, valid_d;
  logic        go_play, go_idle, to_tail, held, expired, wrap;

  key_edge_sync u_sync (
    .clk      (CLOCK_50),
    .rst_n    (resetn),
    .keys_in  (keys),
    .sync_out (sync),
    .press_out(press_raw)
  );

  assign press   = enable ? press_raw : '0;
  assign held    = sync[idx_q];
  assign expired = hold_q == HOLD_MAX;
  assign half    = 32'(BASE_HALF) + 32'(15 - int'(idx_q)) * 32'(STEP);
  assign wrap    = tone_q == half - 32'd1;

  // Transition decision: disable beats everything, a press beats release or expiry.
  always_comb begin
    go_play = 1'b0;
    go_idle = 1'b0;
    to_tail = 1'b0;
    tgt     = idx_q;
    if (!enable) begin
      go_idle = 1'b1;
    end else if (|press) begin
      go_play = 1'b1;
      tgt     = highest_key(press);
    end else if (state_q == IDLE) begin
      go_idle = 1'b1;
    end else if ((state_q == PLAY && !held && expired) || (state_q == TAIL && expired)) begin
      go_play = |sync;
      go_idle = ~|sync;
      tgt     = highest_key(sync);
    end else if (state_q == PLAY && !held) begin
      to_tail = 1'b1;
    end
  end

  // Counters free-run while a voice sounds; a (re)start or silence clears them.
  always_comb begin
    state_d = to_tail ? TAIL : state_q;
    idx_d   = idx_q;
    hold_d  = expired ? hold_q : hold_q + 24'd1;
    tone_d  = wrap ? '0 : tone_q + 32'd1;
    audio_d = audio_q ^ wrap;
    if (go_play) begin
      state_d = PLAY;
      idx_d   = tgt;
      hold_d  = '0;
      tone_d  = '0;
      audio_d = 1'b0;
    end
    if (go_idle) begin
      state_d = IDLE;
      idx_d   = '0;
      hold_d  = '0;
      tone_d  = '0;
      audio_d = 1'b0;
    end
    sound_d = (state_d == IDLE) ? 3'b000 : sound_code(idx_d);
    valid_d = state_d != IDLE;
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      tone_q  <= '0;
      audio_q <= 1'b0;
      sound_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      tone_q  <= tone_d;
      audio_q <= audio_d;
      sound_q <= sound_d;
      valid_q <= valid_d;
    end
  end

  assign sound       = sound_q;
  assign voice_valid = valid_q;
  assign voice_idx   = idx_q;
  assign audio_out   = audio_q;

endmodule

// File: tb/tb_key_voice_scheduler.sv
// tb_key_voice_scheduler: directed and randomized checks against a behavioural voice model
module tb_key_voice_scheduler;

  localparam int MH = 8;
  localparam int BH = 4;
  localparam int ST = 1;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b1;
  logic [15:0] keys = 16'hFFFF;
  logic [2:0]  sound;
  logic        voice_valid;
  logic [3:0]  voice_idx;
  logic        audio_out;
  logic [8:0]  got;

  int total = 0;
  int bad = 0;

  key_voice_scheduler #(.MIN_HOLD(MH), .BASE_HALF(BH), .STEP(ST)) dut (
    .CLOCK_50   (clk),
    .resetn     (resetn),
    .enable     (enable),
    .keys       (keys),
    .sound      (sound),
    .voice_valid(voice_valid),
    .voice_idx  (voice_idx),
    .audio_out  (audio_out)
  );

  always #5 clk = ~clk;

  assign got = {sound, voice_valid, voice_idx, audio_out};

  // Behavioural model: keys seen two clocks late, a voice described by its key and start cycle.
  logic [15:0] m_s1 = '0, m_s2 = '0, m_prev = '0, m_press = '0;
  int m_fill = 0, m_cyc = 0, m_t0 = 0, m_idx = 0, m_hold = 0;
  bit m_act = 1'b0, m_tail = 1'b0;

  function automatic int top_bit(input logic [15:0] v);
    for (int i = 15; i >= 0; i--)
      if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [2:0] ref_code(input int i);
    case (i)
      15: return 3'b001;
      14: return 3'b010;
      13: return 3'b100;
      12: return 3'b110;
      default: return 3'b011;
    endcase
  endfunction

  function automatic logic [8:0] ref_out();
    int half;
    if (!m_act) return '0;
    half = BH + (15 - m_idx) * ST;
    return {ref_code(m_idx), 1'b1, 4'(m_idx), 1'(((m_cyc - m_t0) / half) % 2)};
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_s1 = '0; m_s2 = '0; m_prev = '0; m_fill = 0; m_cyc = 0; m_t0 = 0;
      m_idx = 0; m_act = 1'b0; m_tail = 1'b0;
    end else begin
      m_cyc++;
      m_press = (enable && m_fill >= 3) ? (m_s2 & ~m_prev) : '0;
      m_hold = (m_cyc - 1 - m_t0 < MH - 1) ? m_cyc - 1 - m_t0 : MH - 1;
      if (!enable) m_act = 1'b0;
      else if (m_press != 0) begin
        m_act = 1'b1; m_tail = 1'b0; m_idx = top_bit(m_press); m_t0 = m_cyc;
      end else if (m_act && (m_tail || !m_s2[m_idx])) begin
        if (m_hold >= MH - 1) begin
          if (m_s2 != 0) begin
            m_tail = 1'b0; m_idx = top_bit(m_s2); m_t0 = m_cyc;
          end else m_act = 1'b0;
        end else m_tail = 1'b1;
      end
      if (m_fill < 3) m_fill++;
      m_prev = m_s2; m_s2 = m_s1; m_s1 = keys;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_for(input int n);
    keys = '0;
    repeat (n) step();
  endtask

  task automatic test_reset();
    resetn = 1'b0; keys = 16'hFFFF; enable = 1'b1;
    step();
    total++;
    if (got !== 9'd0) begin bad++; $display("FAIL reset_hold got=%h want=%h", got, 9'd0); end
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (got !== 9'd0) begin bad++; $display("FAIL reset_held_keys cyc=%0d got=%h want=%h", i, got, 9'd0); end
    end
    idle_for(6);
  endtask

  task automatic test_press_q();
    keys = 16'h8000;
    repeat (3) step();
    total++;
    if (got !== {3'b001, 1'b1, 4'd15, 1'b0}) begin bad++; $display("FAIL q_latency got=%h want=%h", got, {3'b001, 1'b1, 4'd15, 1'b0}); end
    for (int i = 0; i < 16; i++) begin
      step();
      total++;
      if (got !== ref_out()) begin bad++; $display("FAIL q_play cyc=%0d got=%h want=%h", i, got, ref_out()); end
      if (i == 3 || i == 7) begin
        total++;
        if (audio_out !== (i == 3)) begin bad++; $display("FAIL q_tone cyc=%0d got=%b want=%b", i, audio_out, i == 3); end
      end
    end
    keys = '0;
    for (int i = 0; i < 12; i++) begin
      step();
      total++;
      if (got !== ref_out()) begin bad++; $display("FAIL q_release cyc=%0d got=%h want=%h", i, got, ref_out()); end
    end
    total++;
    if (got !== 9'd0) begin bad++; $display("FAIL q_idle got=%h want=%h", got, 9'd0); end
  endtask

  task automatic test_tap_w();
    int cnt;
    cnt = 0;
    keys = 16'h4000;
    repeat (2) step();
    keys = '0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (sound === 3'b010) cnt++;
      total++;
      if (got !== ref_out()) begin bad++; $display("FAIL w_tail cyc=%0d got=%h want=%h", i, got, ref_out()); end
    end
    total++;
    if (cnt != 8) begin bad++; $display("FAIL w_gate_len got=%0d want=%0d", cnt, 8); end
    total++;
    if (got !== 9'd0) begin bad++; $display("FAIL w_idle got=%h want=%h", got, 9'd0); end
  endtask

  task automatic test_retrigger();
    keys = 16'h8000;
    for (int i = 0; i < 12; i++) begin
      step();
      total++;
      if (got !== ref_out()) begin bad++; $display("FAIL rt_q cyc=%0d got=%h want=%h", i, got, ref_out()); end
    end
    keys = 16'hA000;
    repeat (3) step();
    total++;
    if (got !== {3'b100, 1'b1, 4'd13, 1'b0}) begin bad++; $display("FAIL rt_e got=%h want=%h", got, {3'b100, 1'b1, 4'd13, 1'b0}); end
    for (int i = 0; i < 20; i++) begin
      step();
      total++;
      if (got !== ref_out()) begin bad++; $display("FAIL rt_e_play cyc=%0d got=%h want=%h", i, got, ref_out()); end
      if (i == 4 || i == 5) begin
        total++;
        if (audio_out !== (i == 5)) begin bad++; $display("FAIL rt_e_half cyc=%0d got=%b want=%b", i, audio_out, i == 5); end
      end
    end
    keys = 16'h8000;
    repeat (3) step();
    total++;
    if (got[8:1] !== {3'b001, 1'b1, 4'd15}) begin bad++; $display("FAIL rt_fallback got=%h want=%h", got[8:1], {3'b001, 1'b1, 4'd15}); end
    idle_for(12);
  endtask

  task automatic test_same_cycle();
    keys = 16'h9000;
    repeat (3) step();
    total++;
    if (got !== {3'b001, 1'b1, 4'd15, 1'b0}) begin bad++; $display("FAIL qr_start got=%h want=%h", got, {3'b001, 1'b1, 4'd15, 1'b0}); end
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (got !== ref_out()) begin bad++; $display("FAIL qr_play cyc=%0d got=%h want=%h", i, got, ref_out()); end
    end
    keys = 16'h1000;
    repeat (3) step();
    total++;
    if (got[8:1] !== {3'b110, 1'b1, 4'd12}) begin bad++; $display("FAIL qr_to_r got=%h want=%h", got[8:1], {3'b110, 1'b1, 4'd12}); end
    idle_for(12);
  endtask

  task automatic test_enable();
    keys = 16'h8000;
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if (got !== ref_out()) begin bad++; $display("FAIL en_play cyc=%0d got=%h want=%h", i, got, ref_out()); end
    end
    enable = 1'b0;
    step();
    total++;
    if (got !== 9'd0) begin bad++; $display("FAIL en_off got=%h want=%h", got, 9'd0); end
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (got !== 9'd0) begin bad++; $display("FAIL en_held_keys cyc=%0d got=%h want=%h", i, got, 9'd0); end
    end
    idle_for(6);
  endtask

  task automatic test_reset_tail();
    keys = 16'h4000;
    repeat (2) step();
    keys = '0;
    repeat (4) step();
    total++;
    if (got[8:1] !== {3'b010, 1'b1, 4'd14}) begin bad++; $display("FAIL rst_tail_pre got=%h want=%h", got[8:1], {3'b010, 1'b1, 4'd14}); end
    #2 resetn = 1'b0;
    #1;
    total++;
    if (got !== 9'd0) begin bad++; $display("FAIL rst_tail_async got=%h want=%h", got, 9'd0); end
    step();
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if (got !== ref_out()) begin bad++; $display("FAIL rst_tail_after cyc=%0d got=%h want=%h", i, got, ref_out()); end
    end
  endtask

  task automatic test_random();
    int dwell;
    dwell = 0;
    for (int i = 0; i < 800; i++) begin
      if (dwell == 0) begin
        keys = 16'($urandom & $urandom & $urandom);
        enable = $urandom_range(0, 15) != 0;
        dwell = $urandom_range(1, 14);
      end
      dwell--;
      step();
      total++;
      if (got !== ref_out()) begin bad++; $display("FAIL random cyc=%0d keys=%h got=%h want=%h", i, keys, got, ref_out()); end
    end
    enable = 1'b1;
    idle_for(12);
  endtask

  initial begin
    test_reset();
    test_press_q();
    test_tap_w();
    test_retrigger();
    test_same_cycle();
    test_enable();
    test_reset_tail();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_voice_scheduler.md
KEY_VOICE_SCHEDULER -- requirements
Module: key_voice_scheduler

Interface
REQ-001 Parameter MIN_HOLD, default 50000: minimum voice gate time in clocks (1 ms at 50 MHz), range 1..2^24-1.
REQ-002 Parameter BASE_HALF, default 95556: tone half-period in clocks for key q.
REQ-003 Parameter STEP, default 4000: half-period increment per key index below 15.
REQ-004 CLOCK_50  in  1  sole clock; all state changes on rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  high = scheduler active; low = forced silence.
REQ-007 keys  in  16  held-key levels from the keyboard tracker, bit15=q, w, e, r, t, y, u, i, o, p, a, s, d, f, g, bit0=h.
REQ-008 sound  out  3  code of the active voice.
REQ-009 voice_valid  out  1  high while a voice is gated.
REQ-010 voice_idx  out  4  key index of the active voice.
REQ-011 audio_out  out  1  square wave of the active voice.

Function
REQ-012 keys shall pass through a 2-flop synchronizer; a press event is a synchronized bit rising versus its previous synchronized value.
REQ-013 Latency: keys change between edges 0 and 1 shall be reflected on all outputs after edge 3.
REQ-014 Sound code table: q=001, w=010, e=100, r=110, all other keys=011; IDLE=000.
REQ-015 FSM states: IDLE, PLAY, TAIL.
REQ-016 IDLE: any press event -> PLAY with the highest-index pressed key; else stay.
REQ-017 PLAY: a new press event retriggers to the highest-index pressed key; the hold counter and tone counter shall clear, and audio_out shall go 0.
REQ-018 PLAY: active key released with hold_cnt >= MIN_HOLD-1 -> fallback rule; with hold_cnt < MIN_HOLD-1 -> TAIL.
REQ-019 TAIL: the voice keeps sounding; a press event -> PLAY (retrigger); hold_cnt reaching MIN_HOLD-1 -> fallback rule.
REQ-020 Fallback rule: if any synchronized key is still held, go to PLAY on the highest-index held key with counters cleared; otherwise go to IDLE.
REQ-021 Press events take precedence over release or expiry in the same cycle.
REQ-022 hold_cnt shall saturate at MIN_HOLD-1 and never wrap.
REQ-023 Tone half-period shall be BASE_HALF + (15 - voice_idx) * STEP, computed at 32-bit width.
REQ-024 The tone counter shall wrap to 0 at half-period-1 and toggle audio_out on each wrap.
REQ-025 In IDLE: sound=000, voice_valid=0, voice_idx=0, audio_out=0.
REQ-026 enable low shall force IDLE at the next edge with outputs per REQ-025 and suppress press events; keys held when enable rises shall not trigger without a new press.

Reset
REQ-027 resetn low shall immediately clear the FSM to IDLE, all counters and synchronizer flops to 0, and all outputs to REQ-025 values, including mid-PLAY or mid-TAIL.
REQ-028 After resetn rises, keys already high shall not generate press events until released and pressed again.

Structure
REQ-029 Package sampler_pkg shall hold the FSM state enum, the key index constants (KEY_Q=15 ... KEY_H=0), and the sound code table function.
REQ-030 Sub-module key_edge_sync shall implement the synchronizer and the press-event vector; all other logic shall live in key_voice_scheduler.
REQ-031 All outputs shall be registered.

Verification (MIN_HOLD=8, BASE_HALF=4, STEP=1)
REQ-032 Reset: resetn=0 with keys=16'hFFFF -> all outputs 0; after release of resetn, no voice starts while keys stay high.
REQ-033 Press q (16'h8000) -> after 3 edges sound=001, voice_idx=15, voice_valid=1, audio_out toggles every 4 clocks.
REQ-034 Tap w for 2 clocks -> sound=010 held for 8 clocks from voice start (TAIL), then IDLE with outputs 0.
REQ-035 Hold q, then press e -> sound=100, idx=13, half-period 6; release e after 20 clocks -> fallback to q, sound=001.
REQ-036 q and r pressed in the same cycle -> sound=001, idx=15; release q after 10 clocks with r held -> sound=110.
REQ-037 enable dropped during PLAY -> outputs 0 at the next edge; resetn pulsed during TAIL -> immediate outputs 0.
